// File: rtl/layer_scan_ctl.sv
// Frame scan-out sequencer: walks the layer-RAM LED addresses, feeds the WS2812 encoders, then times the reset gap.
// Define LAYER_SCAN_DBUF_EN to enable double-buffered bank swapping at every frame start.
module layer_scan_ctl #(
  parameter int unsigned LED_NUM    = 64,
  parameter logic [15:0] RST_CYCLES = 16'd24000
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       frame_rdy_in,
  output logic       rd_en_out,
  output logic [5:0] rd_addr_out,
  output logic       rd_bank_out,
  output logic       wr_bank_out,
  output logic       data_vld_out,
  input  logic       data_rdy_in,
  output logic       busy_out,
  output logic       frame_done_out,
  output logic [7:0] drop_cnt_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_SEND,
    S_GAP
  } state_t;

  localparam logic [5:0] LAST_ADDR = 6'(LED_NUM - 1);

`ifdef LAYER_SCAN_DBUF_EN
  localparam logic RD_BANK_RST = 1'b1;
`else
  localparam logic RD_BANK_RST = 1'b0;
`endif

  state_t      state_q, state_d;
  logic        pending_q, pending_d;
  logic [5:0]  addr_q, addr_d;
  logic [15:0] gap_q, gap_d;
  logic [7:0]  drop_q, drop_d;
  logic        rdBank_q, rdBank_d;
  logic        wrBank_q, wrBank_d;
  logic        rdEn_q, rdEn_d;
  logic        vld_q, vld_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
      addr_q    <= 6'd0;
      gap_q     <= 16'd0;
      drop_q    <= 8'd0;
      rdBank_q  <= RD_BANK_RST;
      wrBank_q  <= 1'b0;
      rdEn_q    <= 1'b0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      gap_q     <= gap_d;
      drop_q    <= drop_d;
      rdBank_q  <= rdBank_d;
      wrBank_q  <= wrBank_d;
      rdEn_q    <= rdEn_d;
      vld_q     <= vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    addr_d    = addr_q;
    gap_d     = gap_q;
    drop_d    = drop_q;
    rdBank_d  = rdBank_q;
    wrBank_d  = wrBank_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_rdy_in || pending_q) begin
          state_d   = S_READ;
          pending_d = 1'b0;
          addr_d    = 6'd0;
`ifdef LAYER_SCAN_DBUF_EN
          rdBank_d  = wrBank_q;
          wrBank_d  = ~wrBank_q;
`endif
        end
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: state_d = S_SEND;
      S_SEND: begin
        if (vld_q && data_rdy_in) begin
          if (addr_q == LAST_ADDR) begin
            state_d = S_GAP;
            gap_d   = RST_CYCLES - 16'd1;
          end else begin
            state_d = S_READ;
            addr_d  = addr_q + 6'd1;
          end
        end
      end
      S_GAP: begin
        if (gap_q == 16'd0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A frame arriving mid-scan is remembered once; further ones are coalesced and counted.
    if (frame_rdy_in && (state_q != S_IDLE)) begin
      if (!pending_q) begin
        pending_d = 1'b1;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end

    rdEn_d = (state_d == S_READ);
    vld_d  = (state_d == S_SEND);
    busy_d = (state_d != S_IDLE) || done_d;
  end

  assign rd_en_out      = rdEn_q;
  assign rd_addr_out    = addr_q;
  assign rd_bank_out    = rdBank_q;
  assign wr_bank_out    = wrBank_q;
  assign data_vld_out   = vld_q;
  assign busy_out       = busy_q;
  assign frame_done_out = done_q;
  assign drop_cnt_out   = drop_q;

endmodule

// File: tb/tb_layer_scan_ctl.sv
// Self-checking bench for layer_scan_ctl: timestamp-based frame model checked every cycle plus directed literal checks.
// Bank expectations follow LAYER_SCAN_DBUF_EN when the bench is built with it.
module tb_layer_scan_ctl;

  localparam int LED_NUM = 64;
  localparam int RST_CYC = 8;
`ifdef LAYER_SCAN_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       frame_rdy;
  logic       data_rdy;
  logic       rd_en;
  logic [5:0] rd_addr;
  logic       rd_bank;
  logic       wr_bank;
  logic       data_vld;
  logic       busy;
  logic       frame_done;
  logic [7:0] drop_cnt;

  layer_scan_ctl #(
    .LED_NUM   (LED_NUM),
    .RST_CYCLES(16'(RST_CYC))
  ) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .frame_rdy_in  (frame_rdy),
    .rd_en_out     (rd_en),
    .rd_addr_out   (rd_addr),
    .rd_bank_out   (rd_bank),
    .wr_bank_out   (wr_bank),
    .data_vld_out  (data_vld),
    .data_rdy_in   (data_rdy),
    .busy_out      (busy),
    .frame_done_out(frame_done),
    .drop_cnt_out  (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int compared = 0;
  int mismatched = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  // Model: a frame is a list of LED read times; LED k reads at mReadAt, sends from mReadAt+2 until handshake.
  bit mInFrame;
  int mReadAt;
  int mDoneAt;
  int mLed;
  bit mPend;
  int mDrop;
  bit mRdBank;
  bit mWrBank;

  function automatic void modelReset();
    mInFrame = 1'b0;
    mReadAt  = -10;
    mDoneAt  = -10;
    mLed     = 0;
    mPend    = 1'b0;
    mDrop    = 0;
    mRdBank  = DBUF;
    mWrBank  = 1'b0;
  endfunction

  function automatic void modelStep(input int c, input bit fr, input bit dr);
    bit idle;
    idle = !mInFrame && (c >= mDoneAt);
    if (fr && !idle) begin
      if (!mPend) mPend = 1'b1;
      else if (mDrop < 255) mDrop++;
    end
    if (idle && (fr || mPend)) begin
      mPend    = 1'b0;
      mInFrame = 1'b1;
      mReadAt  = c + 1;
      mLed     = 0;
      if (DBUF) begin
        mRdBank = mWrBank;
        mWrBank = !mWrBank;
      end
    end else if (mInFrame && (c >= mReadAt + 2) && dr) begin
      if (mLed == LED_NUM - 1) begin
        mInFrame = 1'b0;
        mDoneAt  = c + RST_CYC + 1;
      end else begin
        mLed++;
        mReadAt = c + 1;
      end
    end
  endfunction

  int doneTimes[$];
  int strobes[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      modelReset();
    end else begin
      checkOutput("rd_en", int'(rd_en), int'(mInFrame && (cyc == mReadAt)));
      checkOutput("data_vld", int'(data_vld), int'(mInFrame && (cyc >= mReadAt + 2)));
      checkOutput("rd_addr", int'(rd_addr), mLed);
      checkOutput("frame_done", int'(frame_done), int'(cyc == mDoneAt));
      checkOutput("busy", int'(busy), int'(mInFrame || (cyc <= mDoneAt)));
      checkOutput("drop_cnt", int'(drop_cnt), mDrop);
      checkOutput("rd_bank", int'(rd_bank), int'(mRdBank));
      checkOutput("wr_bank", int'(wr_bank), int'(mWrBank));
      if (frame_done) doneTimes.push_back(cyc);
      if (rd_en) strobes.push_back(int'(rd_addr));
      modelStep(cyc, frame_rdy, data_rdy);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input bit fr, input bit dr);
    frame_rdy = fr;
    data_rdy  = dr;
    tick(1);
    frame_rdy = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget, output int at);
    int n0;
    bit ok;
    n0 = doneTimes.size();
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (doneTimes.size() > n0) begin
        ok = 1'b1;
        at = doneTimes[n0];
        break;
      end
    end
    if (!ok) checkOutput({name, "_timeout"}, 0, 1);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_rd_en"}, int'(rd_en), 0);
    checkOutput({tag, "_rd_addr"}, int'(rd_addr), 0);
    checkOutput({tag, "_data_vld"}, int'(data_vld), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_frame_done"}, int'(frame_done), 0);
    checkOutput({tag, "_drop_cnt"}, int'(drop_cnt), 0);
    checkOutput({tag, "_rd_bank"}, int'(rd_bank), DBUF ? 1 : 0);
    checkOutput({tag, "_wr_bank"}, int'(wr_bank), 0);
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    #1;
    checkReset("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    int t;
    int at;
    int bad;
    int n0;
    modelReset();
    rst_n     = 1'b1;
    frame_rdy = 1'b0;
    data_rdy  = 1'b1;
    #2 rst_n = 1'b0;
    #2 checkReset("init");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(2);

    $display("[TB] single frame");
    strobes.delete();
    t = cyc;
    applyStimulus(1'b1, 1'b1);
    waitDone("single", 400, at);
    checkOutput("single_done_time", at - t, 201);
    #3;
    checkOutput("single_busy_after", int'(busy), 0);
    tick(1);
    checkOutput("single_strobe_count", strobes.size(), 64);
    bad = 0;
    foreach (strobes[i]) if (strobes[i] != i) bad++;
    checkOutput("single_strobe_addrs", bad, 0);

    $display("[TB] back-pressure");
    tick(2);
    t = cyc;
    applyStimulus(1'b1, 1'b1);
    tick(32);
    data_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #3;
      checkOutput("bp_vld_held", int'(data_vld), 1);
      checkOutput("bp_addr_held", int'(rd_addr), 10);
      @(posedge clk);
      #1;
    end
    data_rdy = 1'b1;
    waitDone("bp", 400, at);
    checkOutput("bp_done_time", at - t, 206);

    $display("[TB] coalescing");
    tick(2);
    t = cyc;
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(10);
      applyStimulus(1'b1, 1'b1);
    end
    waitDone("coal1", 400, at);
    checkOutput("coal_done1_time", at - t, 201);
    #3;
    checkOutput("coal_drop", int'(drop_cnt), 2);
    checkOutput("coal_restart_rd_en", int'(rd_en), 1);
    checkOutput("coal_restart_addr", int'(rd_addr), 0);
    tick(1);
    waitDone("coal2", 400, at);
    checkOutput("coal_done2_time", at - t, 402);

    $display("[TB] drop saturation");
    tick(2);
    frame_rdy = 1'b1;
    tick(300);
    frame_rdy = 1'b0;
    #3;
    checkOutput("sat_drop", int'(drop_cnt), 255);
    tick(500);
    checkOutput("sat_drained", int'(busy), 0);
    pulseReset();

    $display("[TB] pulse on gap end");
    t = cyc;
    applyStimulus(1'b1, 1'b1);
    tick(199);
    applyStimulus(1'b1, 1'b1);
    #3;
    checkOutput("edge_done_pulse", int'(frame_done), 1);
    checkOutput("edge_idle_rd_en", int'(rd_en), 0);
    checkOutput("edge_drop", int'(drop_cnt), 0);
    tick(1);
    #3;
    checkOutput("edge_restart_rd_en", int'(rd_en), 1);
    checkOutput("edge_restart_addr", int'(rd_addr), 0);
    tick(1);
    waitDone("edge", 400, at);
    checkOutput("edge_done2_time", at - t, 402);
    checkOutput("edge_drop_after", int'(drop_cnt), 0);
    pulseReset();

    $display("[TB] bank sequence");
    for (int f = 0; f < 3; f++) begin
      applyStimulus(1'b1, 1'b1);
      #3;
      checkOutput("bank_rd_start", int'(rd_bank), DBUF ? (f % 2) : 0);
      checkOutput("bank_wr_start", int'(wr_bank), DBUF ? ((f + 1) % 2) : 0);
      tick(100);
      checkOutput("bank_rd_mid", int'(rd_bank), DBUF ? (f % 2) : 0);
      checkOutput("bank_wr_mid", int'(wr_bank), DBUF ? ((f + 1) % 2) : 0);
      waitDone("bank", 400, at);
      tick(2);
    end

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 1'b1);
    tick(62);
    checkOutput("abort_vld_before", int'(data_vld), 1);
    checkOutput("abort_addr_before", int'(rd_addr), 20);
    n0 = doneTimes.size();
    pulseReset();
    tick(250);
    checkOutput("abort_no_done", doneTimes.size() - n0, 0);
    checkOutput("abort_idle", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/layer_scan_ctl.md
# layer_scan_ctl

Frame scan-out sequencer for the cube frame buffer. It starts on the write side's end-of-frame pulse and walks the 64 LED addresses of the layer RAMs. For each address it issues one read and hands the read data to the eight parallel WS2812 channel encoders over a valid/ready handshake. After the last LED it times the line-reset gap. Optional double buffering lets SPI writes fill one bank while the other bank scans out.

## Interface
Parameters:
- LED_NUM, 64: LEDs per layer. Legal range 2..64.
- RST_CYCLES, 16'd24000: length of the reset gap in clk_in cycles. Must be ≥1.

Ports:
- clk_in, input, 1: clock.
- rst_n_in, input, 1: reset, asynchronous, active-low.
- frame_rdy_in, input, 1: single-cycle pulse from the SPI write side marking a complete frame.
- rd_en_out, output, 1: layer-RAM read strobe.
- rd_addr_out, output, 6: layer-RAM read address.
- rd_bank_out, output, 1: bank being scanned.
- wr_bank_out, output, 1: bank open to SPI writes.
- data_vld_out, output, 1: RAM output is valid for the encoders.
- data_rdy_in, input, 1: AND of all eight encoders' ready signals.
- busy_out, output, 1: high in any state other than IDLE.
- frame_done_out, output, 1: one-cycle pulse when the reset gap completes.
- drop_cnt_out, output, 8: count of coalesced (dropped) frames. Saturates at 255.

## Operation
- States:
  - IDLE: waiting for a frame.
  - READ: rd_en_out=1 for exactly one cycle.
  - WAIT: one cycle for the registered RAM output.
  - SEND: data_vld_out=1.
  - GAP: reset-gap countdown.
- IDLE → READ when frame_rdy_in or pending is set. Entering READ clears pending, sets rd_addr_out=0 and performs the bank swap (see Configuration).
- READ → WAIT → SEND unconditionally.
- SEND holds until data_vld_out & data_rdy_in. Then:
  - if rd_addr_out == LED_NUM-1: go to GAP and load the counter with RST_CYCLES-1;
  - otherwise: increment rd_addr_out and go to READ.
- GAP decrements the counter each cycle. At 0, pulse frame_done_out and go to IDLE.
- frame_rdy_in while busy sets pending. If pending is already set, pending stays set and drop_cnt_out increments, saturating at 255.
- frame_rdy_in in the same cycle GAP ends sets pending. The next frame then starts after exactly one IDLE cycle.
- rd_addr_out holds its value outside READ/WAIT/SEND. It is reset to 0 only on frame start.
- Reset mid-frame aborts the scan immediately. All state returns to reset values and pending is cleared.

## Timing
- Reset values:
  - state=IDLE, pending=0;
  - rd_en_out=0, rd_addr_out=0, data_vld_out=0;
  - busy_out=0, frame_done_out=0, drop_cnt_out=0;
  - wr_bank_out=0, rd_bank_out=1 (both 0 without the macro).
- All outputs are registered.
- Pulse at cycle T while IDLE:
  - T+1: READ, rd_en_out=1, rd_addr_out=0.
  - T+2: WAIT.
  - T+3: SEND, data_vld_out=1.
- Per LED with data_rdy_in held high: 3 cycles (READ, WAIT, SEND).
- Frame time with data_rdy_in held high: 1 + 3·LED_NUM + RST_CYCLES cycles from pulse to frame_done_out.
- data_vld_out never deasserts in SEND until the handshake completes. rd_addr_out is stable while data_vld_out=1.
- busy_out rises at T+1 and falls the cycle after the frame_done_out pulse.

## Configuration
- LAYER_SCAN_DBUF_EN defined:
  - Double buffering is enabled.
  - On every IDLE→READ transition, wr_bank_out toggles and rd_bank_out takes the old wr_bank_out value. The frame just written is scanned while SPI fills the other bank.
  - Banks never change mid-frame.
- LAYER_SCAN_DBUF_EN undefined:
  - rd_bank_out and wr_bank_out are tied to 0. There is a single shared bank.
  - Frames written during a scan can tear. All other behaviour is identical.

## Test plan
- Single frame, LED_NUM=64, RST_CYCLES=8, data_rdy_in=1, pulse at T → expect:
  - 64 rd_en_out strobes at addresses 0..63;
  - frame_done_out at T+1+192+8;
  - busy_out low the following cycle.
- Back-pressure: hold data_rdy_in=0 for 5 cycles at address 10 → data_vld_out stays high and rd_addr_out stays at 10 for 5 extra cycles. The rest of the frame matches the single-frame case, shifted by 5 cycles.
- Coalescing: 3 frame_rdy_in pulses during one scan → one extra frame runs after one IDLE cycle and drop_cnt_out=2. 300 extra pulses → drop_cnt_out saturates at 255.
- Boundary: frame_rdy_in in the cycle GAP ends → next READ follows after exactly one IDLE cycle, and drop_cnt_out is unchanged.
- Double buffer (macro defined): 3 frames → rd_bank_out goes 0,1,0 and wr_bank_out goes 1,0,1, with no change mid-frame. Macro undefined → both banks stay 0.
- Reset mid-frame: assert rst_n_in during SEND at address 20 → all outputs return to reset values asynchronously, and there is no frame_done_out pulse.
